// File: rtl/mdu_hilo.sv
// rtl/mdu_hilo.sv - iterative multiply/divide unit with architectural HI/LO registers
module mdu_hilo #(
   parameter int WIDTH = 32,
   parameter int ITER  = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] rs_data,
   input  logic [WIDTH-1:0] rt_data,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done
);

   localparam int CW = $clog2(ITER);

   typedef enum logic [1:0] {IDLE, RUN, FIX} stateT;

   stateT                state, nextState;
   logic [CW-1:0]        cnt;
   logic                 isDiv, negRes, negRem;
   logic [WIDTH-1:0]     addend;
   logic [2*WIDTH-1:0]   acc;
   logic [WIDTH-1:0]     hiReg, loReg;
   logic                 doneReg;

   // op[0] set means unsigned, op[1] set means divide
   logic                 isSigned, divZero;
   logic [WIDTH-1:0]     absRs, absRt;
   logic [WIDTH:0]       mulSum;
   logic [2*WIDTH-1:0]   mulNext;
   logic [2*WIDTH:0]     divShift;
   logic [WIDTH:0]       divTrial;
   logic [2*WIDTH-1:0]   divNext;
   logic [2*WIDTH-1:0]   prodFix;
   logic [WIDTH-1:0]     quoFix, remFix;

   assign isSigned = ~op[0];
   assign divZero  = (rt_data == '0);

   // Operand magnitudes; the most negative value maps onto itself, which is correct read as unsigned
   always_comb begin
      absRs = (isSigned && rs_data[WIDTH-1]) ? -rs_data : rs_data;
      absRt = (isSigned && rt_data[WIDTH-1]) ? -rt_data : rt_data;
   end

   // One shift-add step: the multiplier sits in the low half and is consumed LSB first
   always_comb begin
      mulSum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? addend : {WIDTH{1'b0}})};
      mulNext = {mulSum, acc[WIDTH-1:1]};
   end

   // One restoring-divide step: remainder in the high half, quotient bits enter at the bottom
   always_comb begin
      divShift = {acc, 1'b0};
      divTrial = divShift[2*WIDTH:WIDTH] - {1'b0, addend};
      divNext  = divTrial[WIDTH] ? divShift[2*WIDTH-1:0]
                                 : {divTrial[WIDTH-1:0], divShift[WIDTH-1:1], 1'b1};
   end

   // Final sign correction of the magnitude results
   always_comb begin
      prodFix = negRes ? -acc : acc;
      quoFix  = negRes ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      remFix  = negRem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= nextState;
   end

   // Next-state logic
   always_comb begin
      nextState = state;
      case (state)
         IDLE:    if (start) nextState = RUN;
         RUN:     if (cnt == CW'(ITER - 1)) nextState = FIX;
         FIX:     nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   // Outputs decoded from state
   always_comb begin
      busy = (state != IDLE);
   end

   // Datapath: operand capture, iteration, HI/LO update and done pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt     <= '0;
         isDiv   <= 1'b0;
         negRes  <= 1'b0;
         negRem  <= 1'b0;
         addend  <= '0;
         acc     <= '0;
         hiReg   <= '0;
         loReg   <= '0;
         doneReg <= 1'b0;
      end else begin
         doneReg <= (state == FIX);
         case (state)
            IDLE: begin
               if (hi_we) hiReg <= wdata;
               if (lo_we) loReg <= wdata;
               if (start) begin
                  cnt    <= '0;
                  isDiv  <= op[1];
                  // divide by zero keeps the all-ones quotient unnegated
                  negRes <= isSigned & (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]) & ~(op[1] & divZero);
                  negRem <= isSigned & op[1] & rs_data[WIDTH-1];
                  addend <= op[1] ? absRt : absRs;
                  acc    <= {{WIDTH{1'b0}}, (op[1] ? absRs : absRt)};
               end
            end
            RUN: begin
               cnt <= cnt + 1'b1;
               acc <= isDiv ? divNext : mulNext;
            end
            FIX: begin
               if (isDiv) begin
                  hiReg <= remFix;
                  loReg <= quoFix;
               end else begin
                  hiReg <= prodFix[2*WIDTH-1:WIDTH];
                  loReg <= prodFix[WIDTH-1:0];
               end
            end
            default: ;
         endcase
      end
   end

   assign hi   = hiReg;
   assign lo   = loReg;
   assign done = doneReg;

endmodule

// File: tb/tb_mdu_hilo.sv
// tb/tb_mdu_hilo.sv - randomized self-checking bench for mdu_hilo
module tb_mdu_hilo;

   logic        clk = 1'b0;
   logic        rst_n, start, hi_we, lo_we;
   logic [1:0]  op;
   logic [31:0] rs_data, rt_data, wdata;
   logic [31:0] hi, lo;
   logic        busy, done;

   int total = 0;
   int bad   = 0;
   logic [31:0] expHi, expLo;

   mdu_hilo #(.WIDTH(32), .ITER(32)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op),
      .rs_data(rs_data), .rt_data(rt_data), .hi_we(hi_we), .lo_we(lo_we),
      .wdata(wdata), .hi(hi), .lo(lo), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Architectural result {HI, LO} from plain integer arithmetic
   function automatic logic [63:0] refModel(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      logic [63:0] p;
      sa = $signed(a);
      sb = $signed(b);
      case (o)
         2'b00: begin p = sa * sb; return p; end
         2'b01: begin p = {32'b0, a} * {32'b0, b}; return p; end
         2'b10: begin
            if (b == 0) return {a, 32'hFFFF_FFFF};
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
         end
         default: begin
            if (b == 0) return {a, 32'hFFFF_FFFF};
            return {a % b, a / b};
         end
      endcase
   endfunction

   task automatic runOp(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input bit disturb, input bit withMt);
      logic [63:0] e;
      int n, extra;
      bit stable;
      e = refModel(o, a, b);
      @(negedge clk);
      start = 1'b1; op = o; rs_data = a; rt_data = b;
      if (withMt) begin
         hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h5555_0000 | 32'($urandom_range(0, 255));
         expHi = wdata; expLo = wdata;
      end
      @(negedge clk);
      start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      op = 2'($urandom); rs_data = $urandom; rt_data = $urandom;
      n = 0;
      stable = 1'b1;
      while (busy && n < 100) begin
         n++;
         if (hi !== expHi || lo !== expLo) stable = 1'b0;
         if (disturb && n == 5) begin
            start = 1'b1; hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h0000_AAAA;
         end else begin
            start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
         end
         @(negedge clk);
      end
      start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      checkVal({tag, "_latency"}, 64'(n), 64'd33);
      checkVal({tag, "_stable"}, 64'(stable), 64'd1);
      checkVal({tag, "_done"}, 64'(done), 64'd1);
      checkVal({tag, "_hi"}, 64'(hi), 64'(e[63:32]));
      checkVal({tag, "_lo"}, 64'(lo), 64'(e[31:0]));
      expHi = e[63:32];
      expLo = e[31:0];
      extra = 0;
      repeat (3) begin
         @(negedge clk);
         if (done) extra++;
      end
      checkVal({tag, "_single_done"}, 64'(extra), 64'd0);
      checkVal({tag, "_idle"}, 64'(busy), 64'd0);
   endtask

   initial begin
      int dones;
      logic [1:0]  o;
      logic [31:0] a, b;

      // reset with junk on the inputs
      rst_n = 1'b0; start = 1'b1; op = 2'b10; rs_data = $urandom; rt_data = $urandom;
      hi_we = 1'b1; lo_we = 1'b1; wdata = $urandom;
      repeat (3) @(negedge clk);
      checkVal("rst_hi", 64'(hi), 64'd0);
      checkVal("rst_lo", 64'(lo), 64'd0);
      checkVal("rst_busy", 64'(busy), 64'd0);
      checkVal("rst_done", 64'(done), 64'd0);
      start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      checkVal("idle_hi", 64'(hi), 64'd0);
      checkVal("idle_lo", 64'(lo), 64'd0);
      checkVal("idle_busy", 64'(busy), 64'd0);
      checkVal("idle_done", 64'(done), 64'd0);
      expHi = 32'h0;
      expLo = 32'h0;

      // directed cases
      runOp("mult_neg", 2'b00, 32'd7, 32'hFFFF_FFFD, 1'b0, 1'b0);
      runOp("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
      runOp("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
      runOp("divu", 2'b11, 32'd100, 32'd7, 1'b0, 1'b0);
      runOp("divu_zero", 2'b11, 32'h1234, 32'd0, 1'b0, 1'b0);
      runOp("div_zero_neg", 2'b10, 32'hFFFF_FFFB, 32'd0, 1'b0, 1'b0);
      runOp("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
      runOp("mult_min", 2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
      runOp("busy_prot", 2'b01, 32'd3, 32'd5, 1'b1, 1'b0);
      runOp("start_mt", 2'b00, 32'hFFFF_FFFF, 32'd9, 1'b0, 1'b1);

      // randomized operations with a bias towards corner operands
      for (int i = 0; i < 30; i++) begin
         o = 2'($urandom);
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 7))
            0: b = 32'd0;
            1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            2: begin a = $urandom_range(0, 1000); b = $urandom_range(1, 50); end
            3: b = 32'($urandom_range(1, 3)) | (b & 32'h8000_0000);
            default: ;
         endcase
         runOp("rand", o, a, b, i[2], i[3] & i[0]);
      end

      // async reset in the middle of a divide
      @(negedge clk);
      start = 1'b1; op = 2'b10; rs_data = 32'hFFFF_0001; rt_data = 32'd3;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checkVal("arst_busy", 64'(busy), 64'd0);
      checkVal("arst_hi", 64'(hi), 64'd0);
      checkVal("arst_lo", 64'(lo), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      dones = 0;
      repeat (40) begin
         @(negedge clk);
         if (done) dones++;
      end
      checkVal("arst_no_done", 64'(dones), 64'd0);
      checkVal("arst_hi_after", 64'(hi), 64'd0);

      // MTHI/MTLO together in idle
      hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hCAFE_BABE;
      @(negedge clk);
      hi_we = 1'b0; lo_we = 1'b0; wdata = 32'h0;
      checkVal("mt_hi", 64'(hi), 64'hCAFE_BABE);
      checkVal("mt_lo", 64'(lo), 64'hCAFE_BABE);

      // single MTLO leaves HI alone
      lo_we = 1'b1; wdata = 32'h0BAD_F00D;
      @(negedge clk);
      lo_we = 1'b0;
      checkVal("mtlo_hi", 64'(hi), 64'hCAFE_BABE);
      checkVal("mtlo_lo", 64'(lo), 64'h0BAD_F00D);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mdu_hilo.md
Name: mdu_hilo

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers for the single-cycle/pipelined MIPS core.
- Sits directly downstream of the register file. It consumes ReadData1 (rs) and ReadData2 (rt) for MULT, MULTU, DIV and DIVU.
- Serves MFHI/MFLO reads and MTHI/MTLO writes.
- Control asserts start for one cycle, then stalls on busy until done pulses.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- ITER, 32, iteration count per operation; must equal WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a multiply or divide using op, rs_data and rt_data; sampled only in IDLE.
- op  input  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- rs_data  input  32  multiplicand or dividend (ReadData1).
- rt_data  input  32  multiplier or divisor (ReadData2).
- hi_we  input  1  MTHI write enable.
- lo_we  input  1  MTLO write enable.
- wdata  input  32  MTHI/MTLO data.
- hi  output  32  current HI value (MFHI).
- lo  output  32  current LO value (MFLO).
- busy  output  1  operation in progress; core stalls while high.
- done  output  1  one-cycle pulse when HI/LO have been updated by an operation.

Behaviour:
- Reset (async, rst_n=0): hi=0, lo=0, busy=0, done=0, state=IDLE, counter=0. An in-flight operation is discarded.
- States: IDLE, RUN, FIX.
- Edge E0 (IDLE, start=1):
  - Latch op and operand magnitudes. Signed ops take the absolute value; |0x80000000| = 0x80000000 treated as unsigned.
  - Latch result sign flags: product/quotient sign = rs[31]^rt[31]; remainder sign = rs[31]. Flags are zero for unsigned ops.
  - Go to RUN with cnt=0 and busy=1.
- RUN, edges E1..E32: one iteration per edge, cnt increments, leave RUN when cnt reaches ITER-1.
  - Multiply: shift-add on a 64-bit accumulator.
  - Divide: restoring divide, one quotient bit per edge.
- FIX, edge E33:
  - Apply two's-complement negation per the sign flags (64-bit for the product).
  - Write HI/LO. Multiply: HI=product[63:32], LO=product[31:0]. Divide: LO=quotient, HI=remainder.
  - Go to IDLE.
- Timing after FIX: done=1 and busy=0 for the cycle after E33. busy is high for exactly 33 cycles after E0. hi/lo are stable, old values, throughout.
- Divide by zero: no exception. Same latency. LO=0xFFFFFFFF; HI=rs_data as given (signed or unsigned).
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. No trap.
- start while busy (RUN/FIX): ignored, no queueing.
- hi_we/lo_we while busy: ignored.
- hi_we/lo_we in IDLE: write wdata at the edge; both may assert together.
- start together with hi_we/lo_we in IDLE: the MT write is applied at E0, and the operation result later overwrites both registers.
- Operand inputs may change after E0 without effect.
- Output timing: hi/lo are registered with no combinational bypass. done is registered.

Test Plan:
- Reset: rst_n=0 with arbitrary inputs -> hi=0, lo=0, busy=0, done=0. Release, idle 5 cycles -> unchanged.
- MULT sign and latency:
  - op=00, rs=7, rt=0xFFFFFFFD (-3) -> busy high 33 cycles, then done pulses one cycle, hi=0xFFFFFFFF, lo=0xFFFFFFEB.
  - op=01 (MULTU), rs=rt=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV sign handling: op=10, rs=0xFFFFFFF9 (-7), rt=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- Unsigned divide and divide by zero:
  - op=11, rs=100, rt=7 -> lo=14, hi=2.
  - op=11, rs=0x1234, rt=0 -> lo=0xFFFFFFFF, hi=0x1234, same 33-cycle latency.
- Busy protection: start MULTU 3*5. During busy, pulse start with other operands and hi_we with wdata=0xAAAA -> hi=0, lo=15, exactly one done pulse.
- Async reset and MT writes:
  - Start DIV, drop rst_n at cycle 10 -> immediately busy=0, hi=lo=0, no done afterwards.
  - Then hi_we=1, lo_we=1, wdata=0xCAFEBABE in IDLE -> both read 0xCAFEBABE next cycle.
